fluid_level_monitor: RTL
========================

// Module: fluid_level_monitor
// PURPOSE
//  Multi-channel fluid-level supervisor (brake oil, coolant, washer, ...) for the vehicle
//  monitoring subsystem. Each channel compares its sampled level against a low threshold,
//  with persistence filtering and hysteresis, and drives a live warning plus a sticky
//  latched warning that the dashboard controller clears with an acknowledge.
//  Also provides an any-channel summary and a saturating count of warning events.
// PARAMETERS
//  NUM_CH    4   number of monitored channels
//  DATA_W    8   level sample width, unsigned
//  LOW_TH    10  level < LOW_TH counts as a low sample
//  HYST      3   level >= LOW_TH+HYST counts as a recovered sample
//  PERSIST   4   consecutive qualifying valid samples needed to change state (>=1)
//  EVT_W     8   width of the event counter
// PORTS
//  clock         in   1               rising-edge clock
//  reset         in   1               synchronous, active-high
//  sample_valid  in   1               level bus holds new samples this cycle
//  level         in   NUM_CH*DATA_W   channel i = level[i*DATA_W +: DATA_W]
//  ack           in   NUM_CH          per-channel clear request for the latched flag
//  warn          out  NUM_CH          live warning, registered
//  warn_latched  out  NUM_CH          sticky warning, registered
//  warn_any      out  1               OR of warn_latched, registered
//  event_count   out  EVT_W           saturating count of OK->WARN entries, all channels
// BEHAVIOUR
//  Reset: all channels in OK, counters 0; warn, warn_latched, warn_any, event_count = 0
//   on the edge that samples reset=1. Reset mid-operation aborts any pending transition.
//  low  = level < LOW_TH; high = level >= LOW_TH+HYST (DATA_W+1-bit compare, no wrap).
//  Elaboration error if LOW_TH+HYST > 2**DATA_W-1, or if PERSIST < 1.
//  Per-channel FSM, advances only when sample_valid=1; otherwise it holds its state and counter:
//   OK       : low -> PEND_LOW, cnt=1 (PERSIST==1: straight to WARN); else stay.
//   PEND_LOW : low -> cnt+1; cnt reaching PERSIST -> WARN. Not low -> OK, cnt=0.
//   WARN     : high -> PEND_OK, cnt=1 (PERSIST==1: straight to OK); else stay.
//   PEND_OK  : high -> cnt+1; cnt reaching PERSIST -> OK. Not high -> WARN, cnt=0.
//  A level in the band [LOW_TH, LOW_TH+HYST) is neither low nor high.
//  warn[i] = 1 iff next state is WARN or PEND_OK. Registered from the next state, so
//   warn rises on the same edge that takes in the PERSIST-th consecutive low sample.
//   Deassert uses the same timing.
//  warn_latched[i]: set on the OK/PEND_LOW->WARN edge. Cleared by ack[i]=1 only while
//   warn[i]=0. Ack while warn[i]=1 is ignored (not queued). Set and ack in the same
//   cycle: set wins.
//  warn_any = OR of the next value of warn_latched, with the same edge timing.
//  event_count += number of channels entering WARN this cycle. Saturates at 2**EVT_W-1.
//   Simultaneous entries on several channels are all counted.
//  Cnt width $clog2(PERSIST+1). Counts never exceed PERSIST.
// STRUCTURE
//  Package fluid_mon_pkg: state enum {OK, PEND_LOW, WARN, PEND_OK}; the 2-bit state encoding.
//  Sub-module fluid_level_channel contains one FSM, counter, compare and latch; instantiate
//   it NUM_CH times in a generate loop. The top level holds only warn_any, event_count
//   and the population-count adder.
// TESTING (defaults)
//  ch0 = 9 for 4 valid samples -> warn[0]=1 and warn_latched[0]=1 on the 4th sample edge;
//   event_count=1.
//  ch0 = 9,9,9,11,9,9,9 -> warn[0] stays 0 (counter restarts on 11).
//  ch0 in WARN, level=12 for 10 samples -> warn stays 1. Level=13 for 4 samples -> warn=0;
//   warn_latched stays 1 until ack[0], then 0 the next edge.
//  ch0 in WARN, ack[0]=1 -> warn_latched[0] stays 1. Toggle sample_valid=0 for 5 cycles
//   while level=9 -> no state change.
//  All 4 channels = 0 for 4 samples -> event_count += 4 on one edge. Force to 254 and
//   repeat -> event_count saturates at 255.
//  Reset asserted in PEND_LOW with cnt=3 -> next edge all outputs 0. A following low
//   sample restarts at cnt=1.

Source files
------------

// File: rtl/fluid_mon_pkg.sv
// Shared types and helpers for the multi-channel fluid-level supervisor.
package fluid_mon_pkg;

  // Per-channel supervision state with a fixed 2-bit encoding
  typedef enum logic [1:0] {
    ST_OK       = 2'b00,
    ST_PEND_LOW = 2'b01,
    ST_WARN     = 2'b10,
    ST_PEND_OK  = 2'b11
  } ch_state_e;

  // Width of a persistence counter that must hold values 0..persist
  function automatic int cnt_width(input int persist);
    return (persist < 1) ? 1 : $clog2(persist + 1);
  endfunction

  // A channel shows a live warning while warned or still proving recovery
  function automatic logic is_warn_state(input ch_state_e st);
    return (st == ST_WARN) || (st == ST_PEND_OK);
  endfunction

endpackage

// File: rtl/fluid_level_channel.sv
// One supervised fluid channel: threshold compare with hysteresis band,
// persistence filter, live warning and sticky acknowledge-cleared warning.
module fluid_level_channel
  import fluid_mon_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int LOW_TH  = 10,
  parameter int HYST    = 3,
  parameter int PERSIST = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] level,
  input  logic              ack,
  output logic              warn,
  output logic              warn_latched,
  output logic              latched_next,
  output logic              enter_warn
);

  localparam int CNT_W = cnt_width(PERSIST);

  // Thresholds widened by one bit so LOW_TH+HYST can never wrap
  localparam logic [DATA_W:0]  LOW_TH_C  = (DATA_W + 1)'(LOW_TH);
  localparam logic [DATA_W:0]  HIGH_TH_C = (DATA_W + 1)'(LOW_TH + HYST);
  localparam logic [CNT_W-1:0] PERSIST_C = CNT_W'(PERSIST);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
  localparam logic             SINGLE    = (PERSIST == 1);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             warn_q, warn_d;
  logic             latched_q, latched_d;
  logic             is_low, is_high;
  logic             enter_d;

  // Classify the current sample against the low and recovered thresholds
  always_comb begin
    is_low  = ({1'b0, level} < LOW_TH_C);
    is_high = ({1'b0, level} >= HIGH_TH_C);
    cnt_inc = cnt_q + ONE_C;
  end

  // Next-state, persistence counter, live warning and latch logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    if (sample_valid) begin
      case (state_q)
        ST_OK: begin
          if (is_low) begin
            if (SINGLE) begin
              state_d = ST_WARN;
              cnt_d   = '0;
            end else begin
              state_d = ST_PEND_LOW;
              cnt_d   = ONE_C;
            end
          end
        end
        ST_PEND_LOW: begin
          if (is_low) begin
            if (cnt_inc >= PERSIST_C) begin
              state_d = ST_WARN;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = ST_OK;
            cnt_d   = '0;
          end
        end
        ST_WARN: begin
          if (is_high) begin
            if (SINGLE) begin
              state_d = ST_OK;
              cnt_d   = '0;
            end else begin
              state_d = ST_PEND_OK;
              cnt_d   = ONE_C;
            end
          end
        end
        ST_PEND_OK: begin
          if (is_high) begin
            if (cnt_inc >= PERSIST_C) begin
              state_d = ST_OK;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = ST_WARN;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_OK;
          cnt_d   = '0;
        end
      endcase
    end

    enter_d = (state_d == ST_WARN) &&
              ((state_q == ST_OK) || (state_q == ST_PEND_LOW));
    warn_d  = is_warn_state(state_d);

    // Entry sets the latch; ack only clears while the live warning is low
    latched_d = latched_q;
    if (enter_d) begin
      latched_d = 1'b1;
    end else if (ack && !warn_q) begin
      latched_d = 1'b0;
    end
  end

  // Register state, counter and the channel outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_OK;
      cnt_q     <= '0;
      warn_q    <= 1'b0;
      latched_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      warn_q    <= warn_d;
      latched_q <= latched_d;
    end
  end

  assign warn         = warn_q;
  assign warn_latched = latched_q;
  assign latched_next = latched_d;
  assign enter_warn   = enter_d;

endmodule

// File: rtl/fluid_level_monitor.sv
// Multi-channel fluid-level supervisor: per-channel supervision plus an
// any-channel latched summary and a saturating count of warning entries.
module fluid_level_monitor
  import fluid_mon_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 8,
  parameter int LOW_TH  = 10,
  parameter int HYST    = 3,
  parameter int PERSIST = 4,
  parameter int EVT_W   = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     sample_valid,
  input  logic [NUM_CH*DATA_W-1:0] level,
  input  logic [NUM_CH-1:0]        ack,
  output logic [NUM_CH-1:0]        warn,
  output logic [NUM_CH-1:0]        warn_latched,
  output logic                     warn_any,
  output logic [EVT_W-1:0]         event_count
);

  // Reject thresholds that do not fit the sample width and a zero filter
  if (LOW_TH + HYST > (2 ** DATA_W) - 1) begin : g_bad_threshold
    $error("fluid_level_monitor: LOW_TH+HYST exceeds the sample range");
  end
  if (PERSIST < 1) begin : g_bad_persist
    $error("fluid_level_monitor: PERSIST must be at least 1");
  end

  localparam int SUM_W = EVT_W + $clog2(NUM_CH + 1);
  localparam logic [SUM_W-1:0] EVT_MAX_C = {{(SUM_W - EVT_W){1'b0}}, {EVT_W{1'b1}}};

  logic [NUM_CH-1:0] latched_next;
  logic [NUM_CH-1:0] enter_warn;
  logic              warn_any_q, warn_any_d;
  logic [EVT_W-1:0]  event_count_q, event_count_d;
  logic [SUM_W-1:0]  n_enter;
  logic [SUM_W-1:0]  evt_sum;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    fluid_level_channel #(
      .DATA_W (DATA_W),
      .LOW_TH (LOW_TH),
      .HYST   (HYST),
      .PERSIST(PERSIST)
    ) u_ch (
      .clock       (clock),
      .reset       (reset),
      .sample_valid(sample_valid),
      .level       (level[i*DATA_W +: DATA_W]),
      .ack         (ack[i]),
      .warn        (warn[i]),
      .warn_latched(warn_latched[i]),
      .latched_next(latched_next[i]),
      .enter_warn  (enter_warn[i])
    );
  end

  // Count simultaneous warning entries and add them with saturation
  always_comb begin
    n_enter = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      n_enter = n_enter + SUM_W'(enter_warn[i]);
    end
    evt_sum = SUM_W'(event_count_q) + n_enter;
    if (evt_sum > EVT_MAX_C) begin
      event_count_d = {EVT_W{1'b1}};
    end else begin
      event_count_d = evt_sum[EVT_W-1:0];
    end
    warn_any_d = |latched_next;
  end

  // Register the summary flag and the event counter
  always_ff @(posedge clock) begin
    if (reset) begin
      warn_any_q    <= 1'b0;
      event_count_q <= '0;
    end else begin
      warn_any_q    <= warn_any_d;
      event_count_q <= event_count_d;
    end
  end

  assign warn_any    = warn_any_q;
  assign event_count = event_count_q;

endmodule
